// File: rtl/delay_line_ctrl.sv
// Circular delay-buffer sequencer for a 64 x 20-bit RAM with combinational read data.
// Clears the RAM after reset, then runs read-old / write-new per accepted sample strobe.
module delay_line_ctrl #(
    parameter int unsigned DW = 20,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_strobe,
    input  logic [DW-1:0] sample_in,
    input  logic [AW-1:0] delay,
    input  logic [DW-1:0] ram_out,
    output logic          ram_load,
    output logic [DW-1:0] ram_in,
    output logic [AW-1:0] ram_sel,
    output logic [DW-1:0] delayed_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [2:0] {
        StClear = 3'd0,
        StIdle  = 3'd1,
        StRead  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e        state;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] wptr;
    logic [DW-1:0] s_reg;
    logic [DW-1:0] rd_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StClear;
            clr_cnt     <= '0;
            wptr        <= '0;
            s_reg       <= '0;
            rd_reg      <= '0;
            ram_load    <= 1'b0;
            ram_in      <= '0;
            ram_sel     <= '0;
            delayed_out <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b1;
            overrun     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // Only IDLE accepts a strobe; anything else (including DONE) drops it.
            if (sample_strobe && state != StIdle) begin
                overrun <= 1'b1;
            end
            case (state)
                StClear: begin
                    ram_load <= 1'b1;
                    ram_in   <= '0;
                    ram_sel  <= clr_cnt;
                    busy     <= 1'b1;
                    clr_cnt  <= clr_cnt + AW'(1);
                    if (clr_cnt == {AW{1'b1}}) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    ram_load <= 1'b0;
                    if (sample_strobe) begin
                        s_reg   <= sample_in;
                        // Read address is fixed from delay at acceptance; 0 wraps to wptr (64).
                        ram_sel <= wptr - delay;
                        busy    <= 1'b1;
                        state   <= StRead;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StRead: begin
                    rd_reg   <= ram_out;
                    ram_sel  <= wptr;
                    ram_in   <= s_reg;
                    ram_load <= 1'b1;
                    state    <= StWrite;
                end
                StWrite: begin
                    ram_load <= 1'b0;
                    state    <= StDone;
                end
                StDone: begin
                    delayed_out <= rd_reg;
                    out_valid   <= 1'b1;
                    wptr        <= wptr + AW'(1);
                    busy        <= 1'b0;
                    state       <= StIdle;
                end
                default: begin
                    state    <= StClear;
                    clr_cnt  <= '0;
                    ram_load <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a behavioural RAM64 model.
module tb_delay_line_ctrl;

    localparam int unsigned DW = 20;
    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst;
    logic          sample_strobe;
    logic [DW-1:0] sample_in;
    logic [AW-1:0] delay;
    logic [DW-1:0] ram_out;
    logic          ram_load;
    logic [DW-1:0] ram_in;
    logic [AW-1:0] ram_sel;
    logic [DW-1:0] delayed_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    logic [DW-1:0] mem [64];
    int n_vec;
    int n_mis;

    delay_line_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .sample_in     (sample_in),
        .delay         (delay),
        .ram_out       (ram_out),
        .ram_load      (ram_load),
        .ram_in        (ram_in),
        .ram_sel       (ram_sel),
        .delayed_out   (delayed_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_out = mem[ram_sel];
    always @(posedge clk) begin
        if (ram_load) mem[ram_sel] <= ram_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_load"}, 32'(ram_load), 0);
        check_eq({tag, "_sel"}, 32'(ram_sel), 0);
        check_eq({tag, "_in"}, 32'(ram_in), 0);
        check_eq({tag, "_dout"}, 32'(delayed_out), 0);
        check_eq({tag, "_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        check_eq({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("idle_wait", 32'(busy), 0);
    endtask

    task automatic do_reset(input string tag);
        sample_strobe = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(tag);
        rst = 1'b0;
        wait_idle();
    endtask

    // One operation from IDLE: strobe seen at edge N, result sampled after edge N+3.
    task automatic do_op(input logic [DW-1:0] s, input logic [AW-1:0] d,
                         output logic [AW-1:0] rsel, output logic [AW-1:0] wsel,
                         output logic [DW-1:0] dout, output logic hs_ok);
        sample_strobe = 1'b1;
        sample_in     = s;
        delay         = d;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        rsel  = ram_sel;
        hs_ok = busy && !out_valid && !ram_load;
        @(posedge clk); #1;
        wsel  = ram_sel;
        hs_ok = hs_ok && ram_load && (ram_in == s) && busy;
        @(posedge clk); #1;
        hs_ok = hs_ok && !out_valid && !ram_load && busy;
        @(posedge clk); #1;
        hs_ok = hs_ok && out_valid && !busy;
        dout  = delayed_out;
    endtask

    logic [AW-1:0] rs, ws;
    logic [DW-1:0] dv;
    logic          ok;

    initial begin
        int nz;
        int nv;
        n_vec = 0;
        n_mis = 0;
        for (int i = 0; i < 64; i++) mem[i] = 20'hBEE00 | DW'(i);
        rst = 1'b1;
        sample_strobe = 1'b0;
        sample_in = '0;
        delay = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst0");
        rst = 1'b0;

        // Clear sweep: 64 write cycles, with a strobe dropped mid-sweep.
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            check_eq("clr_load", 32'(ram_load), 1);
            check_eq("clr_sel", 32'(ram_sel), 32'(k));
            check_eq("clr_in", 32'(ram_in), 0);
            check_eq("clr_busy", 32'(busy), 1);
            sample_strobe = (k == 10);
        end
        @(posedge clk); #1;
        check_eq("clr_end_load", 32'(ram_load), 0);
        check_eq("clr_end_busy", 32'(busy), 0);
        check_eq("clr_ovr", 32'(overrun), 1);
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] != '0) nz++;
        check_eq("clr_nonzero", 32'(nz), 0);

        do_reset("rst1");

        // delay 1, samples 1..3
        do_op(20'h00001, 6'd1, rs, ws, dv, ok);
        check_eq("a1_rsel", 32'(rs), 63);
        check_eq("a1_wsel", 32'(ws), 0);
        check_eq("a1_dout", 32'(dv), 0);
        check_eq("a1_hs", 32'(ok), 1);
        do_op(20'h00002, 6'd1, rs, ws, dv, ok);
        check_eq("a2_dout", 32'(dv), 1);
        check_eq("a2_hs", 32'(ok), 1);
        do_op(20'h00003, 6'd1, rs, ws, dv, ok);
        check_eq("a3_dout", 32'(dv), 2);
        check_eq("a3_hs", 32'(ok), 1);

        // Reset while in WRITE (wptr 3): write abandoned, slot reads back 0.
        sample_strobe = 1'b1;
        sample_in = 20'h12345;
        delay = 6'd1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        @(posedge clk); #1;
        check_eq("e_wr_load", 32'(ram_load), 1);
        check_eq("e_wr_sel", 32'(ram_sel), 3);
        rst = 1'b1;
        #1;
        check_reset_vals("e_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle();
        check_eq("e_mem3", 32'(mem[3]), 0);
        do_op(20'h00009, 6'd61, rs, ws, dv, ok);
        check_eq("e_rsel", 32'(rs), 3);
        check_eq("e_dout", 32'(dv), 0);

        do_reset("rst2");

        // delay 0 (64), samples 1..65
        for (int i = 1; i <= 65; i++) begin
            do_op(DW'(i), 6'd0, rs, ws, dv, ok);
            check_eq("b_dout", 32'(dv), (i == 65) ? 1 : 0);
            check_eq("b_rsel", 32'(rs), 32'((i - 1) % 64));
            check_eq("b_hs", 32'(ok), 1);
        end
        check_eq("b_wrap_wsel", 32'(ws), 0);

        // wptr 1 -> 2, then delay 5 at wptr 2 wraps to 61
        do_op(20'h00100, 6'd1, rs, ws, dv, ok);
        check_eq("c1_dout", 32'(dv), 65);
        do_op(20'h7FFFF, 6'd5, rs, ws, dv, ok);
        check_eq("c_rsel", 32'(rs), 61);
        check_eq("c_wsel", 32'(ws), 2);
        check_eq("c_dout", 32'(dv), 62);

        // Second strobe 2 cycles after the first, at wptr 3
        sample_strobe = 1'b1;
        sample_in = 20'hAAAAA;
        delay = 6'd1;
        nv = 0;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        @(posedge clk); #1;
        sample_strobe = 1'b1;
        sample_in = 20'h55555;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        check_eq("d_ovr", 32'(overrun), 1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        check_eq("d_valid_cnt", 32'(nv), 1);
        check_eq("d_dout", 32'(delayed_out), 20'h7FFFF);
        check_eq("d_mem3", 32'(mem[3]), 20'hAAAAA);
        check_eq("d_mem4", 32'(mem[4]), 5);
        repeat (20) @(posedge clk);
        #1;
        check_eq("d_ovr_sticky", 32'(overrun), 1);
        do_op(20'h00042, 6'd2, rs, ws, dv, ok);
        check_eq("d_next_wsel", 32'(ws), 4);
        check_eq("d_ovr_still", 32'(overrun), 1);

        do_reset("rst3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequencer that drives a 64-entry x 20-bit sample RAM (RAM64 write-enable/data/address, combinational read data) as a circular delay buffer.
- Per accepted sample strobe: reads the sample written D strobes earlier, then writes the new sample at the write pointer.
- Sits between the oscillator/mixer sample stream and the echo/output stage.
- Clears all 64 RAM words after reset, because the RAM itself has no reset.

Parameters:
- DW, 20, sample width; must match RAM data width.
- AW, 6, address width; depth = 2^AW = 64.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_strobe  in  1  one-cycle pulse: sample_in valid, request one delay operation.
- sample_in  in  DW  new sample; two's complement, passed through unmodified.
- delay  in  AW  delay in strobes; 1..63 = that delay, 0 = 64; captured on strobe acceptance.
- ram_out  in  DW  RAM read data; combinational from ram_sel.
- ram_load  out  1  RAM write enable.
- ram_in  out  DW  RAM write data.
- ram_sel  out  AW  RAM address.
- delayed_out  out  DW  delayed sample; held between updates.
- out_valid  out  1  one-cycle pulse when delayed_out updates.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when a strobe is dropped.

Behaviour:
- Reset (async assert, any state):
  - state = CLEAR, clr_cnt = 0, wptr = 0.
  - delayed_out = 0, out_valid = 0, overrun = 0, ram_load = 0, ram_sel = 0, ram_in = 0, busy = 1.
- RAM port outputs are registered. A write takes effect on the clock edge that follows the cycle in which ram_load = 1.
- CLEAR:
  - ram_load = 1, ram_in = 0, ram_sel = clr_cnt; clr_cnt increments each cycle.
  - Lasts exactly 64 cycles (addresses 0..63), then IDLE.
  - Strobes arriving during CLEAR are dropped and set overrun.
- IDLE:
  - ram_load = 0.
  - On sample_strobe: latch sample_in into s_reg, latch delay into d_reg, go to READ.
- READ (1 cycle):
  - ram_sel = (wptr - d_reg) mod 64, ram_load = 0.
  - d_reg = 0 gives address wptr, i.e. the oldest entry (64-strobe delay).
  - At the end of the cycle, ram_out is captured into rd_reg.
- WRITE (1 cycle):
  - ram_sel = wptr, ram_in = s_reg, ram_load = 1.
- DONE (1 cycle):
  - ram_load = 0; delayed_out <= rd_reg; out_valid = 1.
  - wptr <= wptr + 1 mod 64 (wraps 63 -> 0); then IDLE.
- Latency:
  - strobe accepted at edge N; delayed_out and out_valid visible after edge N+3.
  - busy is high for 3 cycles per operation.
  - Minimum accepted strobe spacing is 4 cycles.
- Ordering: read precedes write in every operation, so with delay 0 the read returns the old contents, never the current sample.
- Strobe while busy: dropped, overrun <= 1. The operation in flight is unaffected. overrun clears only on rst.
- Strobe in the same cycle DONE returns to IDLE: dropped (the FSM is not yet in IDLE), sets overrun.
- A delay change takes effect only at the next accepted strobe.
- Until 64 strobes have been written, reads of unwritten slots return 0 (guaranteed by CLEAR).
- Reset mid-operation: the pending write is abandoned and the full CLEAR sequence reruns.
- Illegal/unused state encodings go to CLEAR.

Test Plan:
- Reset release -> exactly 64 consecutive cycles with ram_load = 1, ram_in = 0, ram_sel = 0..63, busy = 1; then busy = 0; a strobe during this window sets overrun = 1.
- delay = 1; strobes every 4 cycles with samples 0x00001, 0x00002, 0x00003 -> delayed_out = 0x00000, 0x00001, 0x00002; out_valid pulses 3 cycles after each strobe.
- delay = 0; 65 strobes with sample value = index (1..65):
  - first 64 outputs are 0; 65th output is 1.
  - wptr wraps 63 -> 0, visible as ram_sel = 0 in the WRITE of strobe 65.
- delay = 5, wptr = 2 -> READ ram_sel = 61 (wrap-around subtraction); WRITE ram_sel = 2.
- Strobe, then a second strobe 2 cycles later -> second strobe ignored (no extra out_valid, RAM unchanged), overrun = 1, overrun stays 1 until rst.
- Assert rst during the WRITE state -> all outputs at reset values immediately, CLEAR reruns, and the next read of that slot returns 0.
